genclk_nco: RTL and testbench
=============================

# genclk_nco

Parametrised NCO clock-word generator, the next generation of the fixed 8-phase generator. Each enabled cycle it advances a BW-bit phase accumulator by UPSAMPLE·step and emits an UPSAMPLE-bit word of sub-cycle clock samples (MSB first), plus a wrap strobe. A sequential table builder computes the k·step multiples, so the step can be changed at run time without glitching the output. A phase-load port supports synchronised restart. The block sits between the DSP controller's frequency/phase registers and the serializer that consumes o_word.

## Interface
- BW, 32, accumulator/step/phase width in bits (≥ LGUP+2)
- LGUP, 3, log2 of samples per word, range 1..5; UPSAMPLE = 2^LGUP (localparam)

- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_en  in  1  accumulator advance enable
- i_step_stb  in  1  step-load request
- i_step  in  BW  new phase increment per sample (unsigned, fraction of 2^BW)
- o_step_ready  out  1  step loader idle; i_step_stb accepted only when high
- i_phase_stb  in  1  accumulator load request
- i_phase  in  BW  value loaded into accumulator
- o_word  out  UPSAMPLE  clock samples, bit UPSAMPLE-1 earliest
- o_stb  out  1  accumulator carry-out (one full clock period completed) on this word
- o_valid  out  1  o_word/o_stb updated by an accumulation this cycle

## Operation
- Active table M[1..UPSAMPLE], M[k] = k·step mod 2^BW. Shadow table S[1..UPSAMPLE]. Accumulator A.
- Accumulate edge (i_en=1, i_phase_stb=0): A ← (A + M[UP]) mod 2^BW; o_stb ← carry of the BW+1-bit sum; o_word bit (UP−k) ← MSB(A + M[k] mod 2^BW), k=1..UP, with A being the pre-edge value; o_valid ← 1.
- i_en=0, no phase load: A, o_word hold; o_stb ← 0; o_valid ← 0.
- Phase-load edge (i_phase_stb=1): A ← i_phase, regardless of i_en; o_stb ← 0; o_valid ← 0; o_word holds. Phase load has priority over accumulation.
- Step loader FSM, states IDLE, BUILD, COMMIT:
  - IDLE: o_step_ready=1. When i_step_stb=1, latch P ← i_step, S[1] ← i_step, k ← 2, go to BUILD. If UP=2, the sum is still computed in BUILD.
  - BUILD: one multiple per edge: S[k] ← S[k−1] + P (mod 2^BW), k ← k+1. After S[UP] is written, go to COMMIT.
  - COMMIT: M ← S atomically; go to IDLE.
- i_step_stb while o_step_ready=0 is ignored; no queueing.
- Step and phase loads are independent. A simultaneous step accept and phase load are both honoured.
- The accumulator always uses the complete old M or the complete new M, never a mix.
- Reset (async, immediate): A=0, M=S=P=0, FSM=IDLE, o_step_ready=1, o_word=0, o_stb=0, o_valid=0. Reset during BUILD/COMMIT aborts the load; the table stays zero.

## Timing
- Output latency: outputs are registered on the same edge that updates A. Word for pre-edge A is visible one cycle after the enabling cycle.
- Step load accepted at edge E0. S[1] at E0, S[2..UP] at E1..E(UP−1), COMMIT at edge EUP.
- o_step_ready is low from after E0 until after EUP: UP cycles busy.
- Accumulations at edges ≤ EUP use the old M; the first edge using the new step is E(UP+1).
- o_stb is at most one per word; o_stb=1 with step=0 is impossible.

## Test plan
- BW=32, LGUP=3, reset, load step 0x2000_0000, wait for ready, i_en=1 -> every word 0x1E, o_stb=1, o_valid=1 each cycle; o_step_ready low exactly 8 cycles after accept.
- Step 0x1000_0000 from A=0 -> words alternate 0x01 (o_stb=0), 0xFE (o_stb=1).
- Same step, i_phase_stb with i_phase=0x8000_0000 -> load cycle o_valid=0, o_stb=0, word held; next word 0xFE with o_stb=1.
- Running with step 0x1000_0000, request step 0x2000_0000 at E0 -> old alternating pattern through EUP, 0x1E from E(UP+1). A second i_step_stb during busy is ignored (table unchanged).
- i_en low for 5 cycles mid-run -> o_valid=0, o_stb=0, o_word frozen, pattern resumes in phase.
- Assert i_reset_n=0 mid-BUILD (asynchronous, between edges) -> all outputs 0 immediately, ready=1 after release, enabled words 0x00 with o_stb=0 until a new step is loaded.

Source files
------------

// File: rtl/genclk_nco.sv
// genclk_nco: NCO clock-word generator.
// Each enabled cycle the phase accumulator advances by UPSAMPLE*step and
// emits UPSAMPLE sub-cycle clock samples (MSB = earliest) plus a wrap strobe.
// Multiples of the step are built one per cycle into a shadow table and
// committed atomically, so a run-time step change never mixes old and new.
module genclk_nco #(
    parameter int unsigned BW   = 32,
    parameter int unsigned LGUP = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic                 i_step_stb,
    input  logic [BW-1:0]        i_step,
    output logic                 o_step_ready,
    input  logic                 i_phase_stb,
    input  logic [BW-1:0]        i_phase,
    output logic [2**LGUP-1:0]   o_word,
    output logic                 o_stb,
    output logic                 o_valid
);

    localparam int unsigned UP = 32'(1) << LGUP;
    localparam int unsigned KW = LGUP + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUILD  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Step loader state; table index j holds multiple (j+1)*step.
    state_t          r_state;
    logic            r_ready;
    logic [BW-1:0]   r_p;
    logic [KW-1:0]   r_k;
    logic [BW-1:0]   r_s [UP];
    logic [BW-1:0]   r_m [UP];
    // Set when UP*step reaches 2^BW: every word spans a full output period.
    logic            r_s_ovf;
    logic            r_m_ovf;

    // Accumulator and registered outputs.
    logic [BW-1:0]   r_acc;
    logic [UP-1:0]   r_word;
    logic            r_stb;
    logic            r_valid;

    logic [LGUP-1:0] w_kprev;
    logic [LGUP-1:0] w_kcur;
    logic [BW:0]     w_next;
    logic [BW-1:0]   w_sum [UP];
    logic [UP-1:0]   w_word;
    logic [BW:0]     w_full;
    logic            w_wrap;

    // Next shadow multiple: S[k] = S[k-1] + P, carry kept for the overflow flag.
    always_comb begin
        w_kprev = LGUP'(r_k - KW'(2));
        w_kcur  = LGUP'(r_k - KW'(1));
        w_next  = {1'b0, r_s[w_kprev]} + {1'b0, r_p};
    end

    // Step loader FSM: latch, build one multiple per cycle, commit atomically.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_p     <= '0;
            r_k     <= '0;
            r_s_ovf <= 1'b0;
            r_m_ovf <= 1'b0;
            for (int i = 0; i < int'(UP); i++) begin
                r_s[i] <= '0;
                r_m[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_step_stb) begin
                        r_p     <= i_step;
                        r_s[0]  <= i_step;
                        r_k     <= KW'(2);
                        r_s_ovf <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    r_s[w_kcur] <= w_next[BW-1:0];
                    r_s_ovf     <= r_s_ovf | w_next[BW];
                    r_k         <= r_k + KW'(1);
                    if (r_k == KW'(UP)) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_m     <= r_s;
                    r_m_ovf <= r_s_ovf;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sub-cycle phases for the current word and the end-of-word sum.
    always_comb begin
        w_word = '0;
        for (int j = 0; j < int'(UP); j++) begin
            w_sum[j]             = r_acc + r_m[j];
            w_word[UP-1-32'(j)]  = w_sum[j][BW-1];
        end
        w_full = {1'b0, r_acc} + {1'b0, r_m[UP-1]};
        w_wrap = w_full[BW] | r_m_ovf;
    end

    // Accumulator with phase-load priority; outputs registered with it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc   <= '0;
            r_word  <= '0;
            r_stb   <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_phase_stb) begin
            r_acc   <= i_phase;
            r_stb   <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_acc   <= w_full[BW-1:0];
            r_word  <= w_word;
            r_stb   <= w_wrap;
            r_valid <= 1'b1;
        end else begin
            r_stb   <= 1'b0;
            r_valid <= 1'b0;
        end
    end

    assign o_step_ready = r_ready;
    assign o_word       = r_word;
    assign o_stb        = r_stb;
    assign o_valid      = r_valid;

endmodule

// File: tb/tb_genclk_nco.sv
// Bench for genclk_nco (BW=32, LGUP=3): stimulus pushes expected words into a
// queue, a negedge monitor pops and compares whenever o_valid is high.
module tb_genclk_nco;

    localparam int unsigned BW = 32;
    localparam int unsigned UP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          step_stb = 1'b0;
    logic [BW-1:0] step = '0;
    logic          phase_stb = 1'b0;
    logic [BW-1:0] phase = '0;
    logic          o_step_ready;
    logic [UP-1:0] o_word;
    logic          o_stb;
    logic          o_valid;

    genclk_nco #(.BW(BW), .LGUP(3)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_en         (en),
        .i_step_stb   (step_stb),
        .i_step       (step),
        .o_step_ready (o_step_ready),
        .i_phase_stb  (phase_stb),
        .i_phase      (phase),
        .o_word       (o_word),
        .o_stb        (o_stb),
        .o_valid      (o_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] w;
        logic       s;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_step = '0;
    logic [31:0] m_pend_step = '0;
    int          m_pend = 0;
    logic [7:0]  mon_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference NCO word from exact integer phase arithmetic.
    function automatic void nco(input logic [31:0] a, input logic [31:0] st,
                                output logic [7:0] w, output logic s, output logic [31:0] na);
        logic [63:0] t;
        w = '0;
        for (int k = 1; k <= 8; k++) begin
            t = 64'(a) + 64'(st) * 64'(k);
            w[8-k] = t[31];
        end
        t  = 64'(a) + 64'(st) * 64'd8;
        s  = (t >= 64'h1_0000_0000);
        na = t[31:0];
    endfunction

    // One clock edge with the current inputs; use_c pushes a hand-computed word.
    task automatic tick(input bit use_c = 1'b0, input logic [7:0] cw = 8'h00, input logic cs = 1'b0);
        exp_t        e;
        logic [7:0]  w;
        logic        s;
        logic [31:0] na;
        if (!phase_stb && en) begin
            nco(m_acc, m_step, w, s, na);
            e.w = use_c ? cw : w;
            e.s = use_c ? cs : s;
            q.push_back(e);
            m_acc = na;
        end
        if (phase_stb) m_acc = phase;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) m_step = m_pend_step;
        end else if (step_stb) begin
            m_pend      = UP;
            m_pend_step = step;
        end
        @(posedge clk);
        #1;
        check("step_ready", 32'(o_step_ready), 32'(m_pend == 0));
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_last = '0;
        end else if (o_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h with nothing expected (t=%0t)", o_word, $time);
            end else begin
                e = q.pop_front();
                check("word", 32'(o_word), 32'(e.w));
                check("stb", 32'(o_stb), 32'(e.s));
            end
            mon_last = o_word;
        end else begin
            check("held_word", 32'(o_word), 32'(mon_last));
            check("idle_stb", 32'(o_stb), 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check("rst_word", 32'(o_word), 32'h0);
        check("rst_stb", 32'(o_stb), 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_ready", 32'(o_step_ready), 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Step 1/8 period per sample: full period per word
        step = 32'h2000_0000; step_stb = 1'b1; tick(); step_stb = 1'b0;
        repeat (8) tick();
        en = 1'b1;
        repeat (6) tick(1'b1, 8'h1E, 1'b1);
        en = 1'b0;

        // Step 1/16: half period per word, alternating
        step = 32'h1000_0000; step_stb = 1'b1; tick(); step_stb = 1'b0;
        repeat (8) tick();
        en = 1'b1;
        repeat (3) begin
            tick(1'b1, 8'h01, 1'b0);
            tick(1'b1, 8'hFE, 1'b1);
        end

        // Phase load to half period
        phase = 32'h8000_0000; phase_stb = 1'b1; tick(); phase_stb = 1'b0;
        tick(1'b1, 8'hFE, 1'b1);
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'hFE, 1'b1);

        // Run-time step change; second request while busy is ignored
        tick(1'b1, 8'h01, 1'b0);
        step = 32'h2000_0000; step_stb = 1'b1; tick(); step_stb = 1'b0;
        tick(); tick();
        step = 32'h4000_0000; step_stb = 1'b1; tick(); step_stb = 1'b0;
        repeat (5) tick();
        repeat (4) tick(1'b1, 8'h1E, 1'b1);

        // Simultaneous step and phase load, then enable gap
        step = 32'h1000_0000; step_stb = 1'b1;
        phase = 32'h0000_0000; phase_stb = 1'b1;
        tick();
        step_stb = 1'b0; phase_stb = 1'b0;
        repeat (8) tick();
        repeat (3) tick();
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        repeat (4) tick();

        // Asynchronous reset in the middle of a table build
        en = 1'b0;
        step = 32'h3000_0000; step_stb = 1'b1; tick(); step_stb = 1'b0;
        tick(); tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_word", 32'(o_word), 32'h0);
        check("mid_rst_stb", 32'(o_stb), 32'h0);
        check("mid_rst_valid", 32'(o_valid), 32'h0);
        check("mid_rst_ready", 32'(o_step_ready), 32'h1);
        m_acc = '0; m_step = '0; m_pend = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(o_step_ready), 32'h1);
        en = 1'b1;
        repeat (4) tick(1'b1, 8'h00, 1'b0);

        // Recovery with a fresh step
        step = 32'h1000_0000; step_stb = 1'b1; tick(); step_stb = 1'b0;
        repeat (8) tick();
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'hFE, 1'b1);

        en = 1'b0;
        tick(); tick();
        check("queue_empty", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
